// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: funct3 opcodes, FSM states and operand-sign helpers for the RV32M unit.
package muldiv_seq_pkg;
  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  localparam logic [31:0] MD_DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIX  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return op == MD_OP_MULH || op == MD_OP_MULHSU || op == MD_OP_DIV || op == MD_OP_REM;
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op == MD_OP_MULH || op == MD_OP_DIV || op == MD_OP_REM;
  endfunction
endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: hi/lo shift registers around one 33-bit add/sub; multiply keeps {hi,lo}
// as the product, divide reuses hi as remainder and lo as quotient.
module muldiv_iter_dp
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, a_mag, b_mag, lo_n, hi_n;
  logic             is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d, a_neg, b_neg;
  logic [WIDTH:0]   x, y, sum;

  always_comb begin
    a_neg    = op_a_signed(op) && a[WIDTH-1];
    b_neg    = op_b_signed(op) && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    // Divide subtracts the divisor from the shifted remainder; multiply adds the multiplicand.
    x        = is_div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    y        = {1'b0, b_q} ^ {(WIDTH+1){is_div_q}};
    sum      = x + y + (WIDTH+1)'(is_div_q);
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    if (load) begin
      hi_d     = '0;
      lo_d     = a_mag;
      b_d      = b_mag;
      is_div_d = op[2];
      sel_hi_d = op[2] ? op[1] : op[1:0] != 2'b00;
      neg_d    = (op[2] && op[1]) ? a_neg : a_neg ^ b_neg;
    end else if (step) begin
      if (is_div_q) begin
        hi_d = sum[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ~sum[WIDTH]};
      end else begin
        {hi_d, lo_d} = lo_q[0] ? {sum, lo_q[WIDTH-1:1]} : {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
    end
    // High word of a negated 64-bit product only takes the +1 carry when lo is zero.
    lo_n   = neg_q ? -lo_q : lo_q;
    hi_n   = neg_q ? ~hi_q + WIDTH'(is_div_q || lo_q == '0) : hi_q;
    result = sel_hi_q ? hi_n : lo_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      neg_q    <= neg_d;
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide with valid/ready request and response;
// divide-by-zero and signed overflow bypass the iteration and answer the next cycle.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d, dp_result, spec_result;
  logic             accept, div0, ovf, special, load, step;

  always_comb begin
    accept       = state_q == MD_ST_IDLE && req_valid && !flush;
    div0         = req_op[2] && req_b == '0;
    ovf          = req_op[2] && !req_op[0] && req_a == {1'b1, {(WIDTH-1){1'b0}}} && req_b == '1;
    special      = div0 || ovf;
    spec_result  = div0 ? (req_op[1] ? req_a : MD_DIV_ZERO_Q) : (req_op[1] ? '0 : req_a);
    load         = accept && !special;
    step         = state_q == MD_ST_CALC;
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      MD_ST_IDLE: if (accept) begin
        state_d      = special ? MD_ST_DONE : MD_ST_CALC;
        cnt_d        = CNT_W'(WIDTH);
        resp_valid_d = special;
        resp_data_d  = special ? spec_result : resp_data_q;
      end
      MD_ST_CALC: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? MD_ST_FIX : MD_ST_CALC;
      end
      MD_ST_FIX: begin
        state_d      = MD_ST_DONE;
        resp_valid_d = 1'b1;
        resp_data_d  = dp_result;
      end
      MD_ST_DONE: if (resp_ready) begin
        state_d      = MD_ST_IDLE;
        resp_valid_d = 1'b0;
      end
      default: state_d = MD_ST_IDLE;
    endcase
    if (flush) begin
      state_d      = MD_ST_IDLE;
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MD_ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .op     (req_op),
    .a      (req_a),
    .b      (req_b),
    .result (dp_result)
  );

  assign req_ready  = state_q == MD_ST_IDLE;
  assign busy       = state_q != MD_ST_IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq covering results, latency, backpressure, flush and reset.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_data;
  int          errors = 0, checks = 0;
  logic [31:0] exp_q[$];

  muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                       input logic [31:0] exp, input bit push);
    @(negedge clk);
    check({tag, "_idle"}, {resp_valid, req_ready, busy}, 3'b010);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic collect(input string tag, input int lat, input int hold);
    int n = 0;
    logic [31:0] held;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check(tag, resp_data, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
    held = resp_data;
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold"}, {resp_valid, req_ready, busy, resp_data}, {1'b1, 1'b0, 1'b1, held});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                     input logic [31:0] exp, input int lat);
    issue(tag, op, a, b, exp, 1'b1);
    collect(tag, lat, 0);
  endtask

  initial begin
    int seen;
    #1 check("reset", {req_ready, resp_valid, busy, resp_data}, {1'b1, 1'b0, 1'b0, 32'h0});
    #21 rst_n = 1'b1;

    run("mul",    MD_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulhu",  MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulh",   MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhsu", MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("mulh_n", MD_OP_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34);
    run("divu",   MD_OP_DIVU,   32'd100,      32'd7,         32'd14,        34);
    run("remu",   MD_OP_REMU,   32'd100,      32'd7,         32'd2,         34);
    run("div",    MD_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem",    MD_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("div0",   MD_OP_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, 1);
    run("remu0",  MD_OP_REMU,   32'd5,        32'd0,         32'd5,         1);
    run("ovf_d",  MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("ovf_r",  MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    issue("bp", MD_OP_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
    collect("bp", 34, 10);
    run("b2b", MD_OP_MUL, 32'd6, 32'd7, 32'd42, 34);

    issue("fl", MD_OP_MUL, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {resp_valid, req_ready, busy}, 3'b010);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("flush_noresp", 64'(seen), 64'd0);
    run("post_fl", MD_OP_MUL, 32'd3, 32'd4, 32'd12, 34);

    issue("rst", MD_OP_DIVU, 32'd1000, 32'd7, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {req_ready, resp_valid, busy, resp_data}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", MD_OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide unit beside the EX-stage ALU. Accepts one operation through a valid/ready handshake and runs a radix-2 shift-add multiply or restoring divide over 32 iterations, using a single 33-bit add/sub. It then returns the result through a valid/ready handshake. The EX stage holds its pipeline on `busy` until the response is consumed.

Parameters:
- WIDTH, 32: operand/result width; only 32 is supported.
- CNT_W, 6: iteration counter width; must be ≥ clog2(WIDTH)+1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the in-flight op (branch mispredict/trap)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (state==IDLE)
- req_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  in  WIDTH  rs1 value
- req_b  in  WIDTH  rs2 value
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  WIDTH  result
- busy  out  1  state!=IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; req_ready=1; resp_valid=0; resp_data=0; busy=0; counter and datapath registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on req_valid&&req_ready, latch op. Latch operands as magnitudes: signed operands are negated if negative (MULH: both signed; MULHSU: a signed; DIV/REM: both signed). Latch result sign flags. Load counter=WIDTH. Go to CALC, unless a special case applies (below).
- Special cases, decided at accept; go directly to DONE, so resp_valid is high the cycle after accept:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → req_a.
  - Signed overflow (req_a=0x80000000, req_b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- CALC: one iteration per cycle; counter decrements; at counter==1 go to FIX. Exactly 32 CALC cycles.
  - Multiply: 64-bit {hi,lo} product register. If lo[0], hi+=multiplicand (33-bit carry kept); then shift right 1.
  - Divide: {rem,quo} shift left 1; trial = rem−divisor (33-bit). If non-negative, rem=trial and quo[0]=1.
- FIX, one cycle:
  - Apply two's-complement negation where the sign flag requires it. Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
  - Select the result: MUL → lo; MULH* → hi; DIV* → quo; REM* → rem.
  - Register the result into resp_data and go to DONE.
- DONE: resp_valid=1 and resp_data is stable. On resp_ready, go to IDLE next cycle, with resp_valid low that cycle. While resp_ready=0, hold indefinitely with no change.
- Latency: accept at cycle T → resp_valid first high at T+34 for normal ops, T+1 for special cases. Throughput: a new accept is possible the cycle after the handshake completes; no accept in the same cycle as the response handshake.
- flush: has priority over all transitions. Next state is IDLE, resp_valid=0, result discarded. A flush in IDLE ignores a coincident req_valid (no accept).
- rst_n assertion mid-operation: immediate return to reset values; no response is produced.
- req_* are ignored outside IDLE; the requester must hold them stable only until the accept cycle.

Decomposition:
- Shared header defines.vh:
  - MD_OP_* funct3 constants (8)
  - MD_ST_IDLE/CALC/FIX/DONE 2-bit state encodings
  - MD_DIV_ZERO_Q constant 32'hFFFFFFFF
- Natural sub-module: muldiv_iter_dp. It holds the 33-bit add/sub, hi/lo (rem/quo) shift registers and the negate-on-load/negate-on-fix logic, controlled by load/step/fix strobes from the FSM in muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → resp_data=0xFFFFFFEB at T+34; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100/7 → 14, REMU → 2; DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; each at T+34.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5 at T+1; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, at T+1.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid → resp_valid and resp_data stable, req_ready=0, busy=1. Raise resp_ready → IDLE next cycle, then a back-to-back request is accepted.
- flush at CALC cycle 10 → resp_valid never asserts, req_ready=1 next cycle. A new MUL 3×4 → 12 completes correctly with no stale state.
- rst_n low mid-CALC (async, between edges) → outputs reach reset values immediately. After release, DIVU 9/3 → 3.
